clock_mode_ctrl: RTL

- Front-panel sequencer for the digital clock/alarm design.
- Converts three debounced push-buttons into the setting controls for the timekeeping counter and the alarm block: setting enables, hour/minute select and single-cycle increment pulses.
- Adds long-press auto-repeat, an idle timeout back to run mode, and beep acknowledge.
- Sits between the button debouncers and the time/alarm datapaths.

---
 rtl/clock_ctrl_pkg.sv | 27 ++
 rtl/btn_edge.sv | 25 ++
 rtl/clock_mode_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared state codes, field-select constants and mode sequencing for the clock front panel.
package clock_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_CLK = 2'd1;
  localparam logic [1:0] ST_SET_ALM = 2'd2;

  localparam logic SEL_HOUR = 1'b1;
  localparam logic SEL_MIN  = 1'b0;

  typedef enum logic [1:0] {
    StRun    = ST_RUN,
    StSetClk = ST_SET_CLK,
    StSetAlm = ST_SET_ALM,
    StRsvd   = 2'd3
  } mode_e;

  // Mode button cycles RUN -> SET_CLK -> SET_ALM -> RUN; the unused code falls back to RUN.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      StRun:    return StSetClk;
      StSetClk: return StSetAlm;
      default:  return StRun;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button: previous-value register plus press pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = btn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign press = btn & ~prev_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel sequencer: mode FSM, field select, increment pulses, idle timeout and beep ack.
// Long-press auto-repeat is built only when CLOCK_MODE_CTRL_AUTO_REPEAT_EN is defined.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 25000000,
  parameter int unsigned REPEAT_CYC  = 5000000,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       beep_in,
  output logic       clk_set_en,
  output logic       alm_set_en,
  output logic       set_hr_or_min,
  output logic       inc_short,
  output logic       beep_ack,
  output logic [1:0] mode_code
);

  localparam int unsigned IdleW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);

  logic mode_p, sel_p, inc_p, any_press, in_set;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(mode_p));
  btn_edge u_edge_sel  (.clk(clk), .rst(rst), .btn(btn_sel),  .press(sel_p));
  btn_edge u_edge_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .press(inc_p));

  mode_e            state_q, state_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             hr_q, hr_d, inc_q, inc_d, ack_q, ack_d;
  logic             clk_en_q, clk_en_d, alm_en_q, alm_en_d;

`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned HoldW  = (RptMax > 1) ? $clog2(RptMax) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
  localparam logic [HoldW-1:0] RptLast  = HoldW'(REPEAT_CYC - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             armed_q, armed_d, rpt_q, rpt_d, rpt_fire;

  // The first wait after a pulse is HOLD_CYC long, every later one REPEAT_CYC.
  assign rpt_fire = armed_q && btn_inc && (hold_q == (rpt_q ? RptLast : HoldLast));

  always_comb begin
    armed_d = armed_q;
    rpt_d   = rpt_q;
    hold_d  = hold_q;
    if (!btn_inc || state_d != state_q) begin
      armed_d = 1'b0;
      rpt_d   = 1'b0;
      hold_d  = '0;
    end else if (!armed_q) begin
      // Only a press that really produced a pulse arms repeat; a beep-consumed press never does.
      if (inc_d) begin
        armed_d = 1'b1;
        rpt_d   = 1'b0;
        hold_d  = '0;
      end
    end else if (rpt_fire) begin
      rpt_d  = 1'b1;
      hold_d = '0;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      rpt_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      armed_q <= armed_d;
      rpt_q   <= rpt_d;
      hold_q  <= hold_d;
    end
  end
`endif

  always_comb begin
    any_press = mode_p | sel_p | inc_p;
    in_set    = (state_q == StSetClk) || (state_q == StSetAlm);
    state_d   = state_q;
    hr_d      = hr_q;
    inc_d     = 1'b0;
    ack_d     = 1'b0;
    // Priority: beep ack swallows the press, then mode > sel > inc, then timeout expiry.
    if (any_press && beep_in) begin
      ack_d = 1'b1;
    end else if (mode_p) begin
      state_d = next_mode(state_q);
    end else if (sel_p) begin
      if (in_set) hr_d = (hr_q == SEL_HOUR) ? SEL_MIN : SEL_HOUR;
    end else if (inc_p) begin
      inc_d = in_set;
    end else if (in_set && idle_q == IdleLast) begin
      state_d = StRun;
    end
    if (state_q == StRsvd) state_d = StRun;
    if (state_d != state_q && state_d != StRun) hr_d = SEL_HOUR;
`ifdef CLOCK_MODE_CTRL_AUTO_REPEAT_EN
    if (rpt_fire && state_d == state_q) inc_d = 1'b1;
`endif
    idle_d   = (!in_set || state_d != state_q || any_press || btn_inc) ? '0 : idle_q + 1'b1;
    clk_en_d = (state_d == StSetClk);
    alm_en_d = (state_d == StSetAlm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      idle_q   <= '0;
      hr_q     <= SEL_HOUR;
      inc_q    <= 1'b0;
      ack_q    <= 1'b0;
      clk_en_q <= 1'b0;
      alm_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      hr_q     <= hr_d;
      inc_q    <= inc_d;
      ack_q    <= ack_d;
      clk_en_q <= clk_en_d;
      alm_en_q <= alm_en_d;
    end
  end

  assign mode_code     = state_q;
  assign clk_set_en    = clk_en_q;
  assign alm_set_en    = alm_en_q;
  assign set_hr_or_min = hr_q;
  assign inc_short     = inc_q;
  assign beep_ack      = ack_q;

endmodule
